vmem_scan_reader: RTL and testbench



---
 rtl/vmem_scan_pkg.sv | 35 +++
 rtl/vmem_scan_reader_if.sv | 10 +
 rtl/vmem_scan_timing.sv | 65 ++++++
 rtl/vmem_scan_reader.sv | 105 ++++++++++
 tb/tb_vmem_scan_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vmem_scan_pkg.sv
// Shared widths, default raster timing and helpers for the video memory scan reader.
package vmem_scan_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    localparam int DEF_H_ACTIVE = 160;
    localparam int DEF_H_FP     = 4;
    localparam int DEF_H_SYNC   = 12;
    localparam int DEF_H_BP     = 8;
    localparam int DEF_V_ACTIVE = 120;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 4;

    localparam bit                DEF_SYNC_POL  = 1'b0;
    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 15'd0;

    // Per-position decode carried down the pipeline; sync bits are active-high here.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } scan_flags_t;

    function automatic int scan_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vmem_scan_reader_if.sv
// Combinational read port between the scan reader (master) and the video memory (slave).
interface vmem_scan_reader_if;
    import vmem_scan_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_addr, input  mem_data);
    modport slave  (input  mem_addr, output mem_data);
endinterface

// File: rtl/vmem_scan_timing.sv
// Horizontal/vertical raster counters with active, sync and first-pixel decode.
// Latency: decode is combinational from the counters (stage 0).
// Backpressure: none; counters advance only on pix_en and park at origin while enable is low.
module vmem_scan_timing import vmem_scan_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pix_en,
    output scan_flags_t flags,
    output logic        eof
);

    localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [31:0]   h32;
    logic [31:0]   v32;
    logic          h_last;
    logic          v_last;

    assign h32    = 32'(h_cnt);
    assign v32    = 32'(v_cnt);
    assign h_last = (h32 == 32'(H_TOTAL - 1));
    assign v_last = (v32 == 32'(V_TOTAL - 1));
    assign eof    = h_last && v_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (!enable) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        flags        = '0;
        flags.active = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
        flags.hsync  = (h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
        flags.vsync  = (v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
        flags.first  = (h32 == 32'd0) && (v32 == 32'd0);
    end

endmodule

// File: rtl/vmem_scan_reader.sv
// Raster scan reader: fetches one byte per active pixel and emits aligned pixel/de/hsync/vsync.
// Latency: 2 pix_en ticks from counter position to outputs; frame_start is a single-clk pulse.
// Backpressure: none; pix_en gates every register, so mem_addr and outputs hold while it is low.
module vmem_scan_reader import vmem_scan_pkg::*; #(
    parameter int                H_ACTIVE  = DEF_H_ACTIVE,
    parameter int                H_FP      = DEF_H_FP,
    parameter int                H_SYNC    = DEF_H_SYNC,
    parameter int                H_BP      = DEF_H_BP,
    parameter int                V_ACTIVE  = DEF_V_ACTIVE,
    parameter int                V_FP      = DEF_V_FP,
    parameter int                V_SYNC    = DEF_V_SYNC,
    parameter int                V_BP      = DEF_V_BP,
    parameter bit                SYNC_POL  = DEF_SYNC_POL,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pix_en,
    vmem_scan_reader_if.master mem,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [DATA_W-1:0]  pixel,
    output logic               frame_start
);

    scan_flags_t       st0;
    scan_flags_t       st1;
    logic              eof;
    logic [ADDR_W-1:0] addr_q;
    logic              de_q;
    logic              hs_q;
    logic              vs_q;

    vmem_scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .pix_en (pix_en),
        .flags  (st0),
        .eof    (eof)
    );

    // Disabling clears stage 1 so the origin decode seen while parked never leaks out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st1 <= '0;
        end else if (pix_en) begin
            st1 <= enable ? st0 : '0;
        end
    end

    // mem_addr belongs to the pixel in stage 1; it steps as that pixel is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= BASE_ADDR;
        end else if (pix_en) begin
            if (!enable || eof) begin
                addr_q <= BASE_ADDR;
            end else if (st1.active) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    assign mem.mem_addr = addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            pixel <= '0;
        end else if (pix_en) begin
            de_q  <= st1.active;
            hs_q  <= st1.hsync;
            vs_q  <= st1.vsync;
            pixel <= st1.active ? mem.mem_data : '0;
        end
    end

    // Not gated by pix_en so the pulse lasts one clk even with a slow pixel tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && st1.first;
        end
    end

    assign de    = de_q;
    assign hsync = SYNC_POL ? hs_q : ~hs_q;
    assign vsync = SYNC_POL ? vs_q : ~vs_q;

endmodule

// File: tb/tb_vmem_scan_reader.sv
// Scoreboarded bench: a raster-position model predicts each tick's outputs; a monitor pops and compares.
module tb_vmem_scan_reader;

    localparam int          HA   = 4;
    localparam int          HFP  = 1;
    localparam int          HS   = 2;
    localparam int          HBP  = 1;
    localparam int          VA   = 2;
    localparam int          VFP  = 1;
    localparam int          VS   = 1;
    localparam int          VBP  = 1;
    localparam int          HT   = HA + HFP + HS + HBP;
    localparam int          VT   = VA + VFP + VS + VBP;
    localparam bit          SPOL = 1'b0;
    localparam logic [14:0] BASE = 15'h7FFE;

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic        first;
        logic [14:0] addr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] pixel;
    logic       frame_start;

    int   nvec;
    int   nmis;
    int   mh;
    int   mv;
    exp_t expq[$];

    vmem_scan_reader_if mif ();

    vmem_scan_reader #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (SPOL), .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pix_en      (pix_en),
        .mem         (mif),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    function automatic logic [7:0] memf(input logic [14:0] a);
        return (a[7:0] + 8'h10) ^ {1'b0, a[14:8]};
    endfunction

    function automatic logic lvl(input logic a);
        return a ? SPOL : ~SPOL;
    endfunction

    assign mif.mem_data = memf(mif.mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nmis = nmis + 1;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a scan position (mh,mv) consumed on each enabled tick; row-contiguous framebuffer.
    task automatic model_tick();
        exp_t e;
        e = '0;
        if (enable) begin
            e.act   = (mh < HA) && (mv < VA);
            e.hs    = (mh >= HA + HFP) && (mh < HA + HFP + HS);
            e.vs    = (mv >= VA + VFP) && (mv < VA + VFP + VS);
            e.first = (mh == 0) && (mv == 0);
            if (e.act) e.addr = 15'(int'(BASE) + mv * HA + mh);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
        expq.push_back(e);
    endtask

    task automatic cyc(input logic pe, input logic en);
        @(posedge clk);
        if (reset && pix_en) model_tick();
        #2;
        pix_en = pe;
        enable = en;
    endtask

    task automatic goto_pos(input int h, input int v);
        for (int i = 0; i < 200 && !(mh == h && mv == v); i++) cyc(1'b1, 1'b1);
        if (!(mh == h && mv == v)) begin
            nvec = nvec + 1;
            nmis = nmis + 1;
            $display("FAIL goto_pos: got (%0d,%0d) required (%0d,%0d)", mh, mv, h, v);
        end
    endtask

    // Monitor: one expected entry retires per pix_en edge; between ticks outputs must hold.
    initial begin : monitor
        exp_t cur;
        exp_t s1;
        logic fs_e;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                cur = '0;
            end else begin
                fs_e = 1'b0;
                if (pix_en) begin
                    if (expq.size() == 0) begin
                        nvec = nvec + 1;
                        nmis = nmis + 1;
                        $display("FAIL scoreboard_empty: got 0 entries required 1");
                    end else begin
                        cur  = expq.pop_front();
                        fs_e = cur.first;
                    end
                end
                chk(pix_en ? "tick_out" : "hold_out",
                    32'({de, hsync, vsync, frame_start, pixel}),
                    32'({cur.act, lvl(cur.hs), lvl(cur.vs), fs_e, cur.act ? memf(cur.addr) : 8'h00}));
                if (expq.size() > 0) begin
                    s1 = expq[$];
                    if (s1.act) chk("mem_addr", 32'(mif.mem_addr), 32'(s1.addr));
                end
            end
        end
    end

    initial begin
        nvec   = 0;
        nmis   = 0;
        mh     = 0;
        mv     = 0;
        enable = 1'b0;
        pix_en = 1'b0;
        reset  = 1'b1;
        expq.push_back('0);
        #1 reset = 1'b0;
        #2;
        chk("reset_out", 32'({de, hsync, vsync, frame_start, pixel}), 32'({1'b0, ~SPOL, ~SPOL, 1'b0, 8'h00}));
        chk("reset_addr", 32'(mif.mem_addr), 32'(BASE));
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        #3 reset = 1'b1;

        repeat (90) cyc(1'b1, 1'b1);

        for (int i = 0; i < 360; i++) cyc((i % 3) == 0, 1'b1);

        goto_pos(2, 1);
        repeat (5) cyc(1'b1, 1'b0);
        repeat (60) cyc(1'b1, 1'b1);

        repeat (600) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 15) != 0);

        goto_pos(2, 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_out", 32'({de, hsync, vsync, frame_start, pixel}), 32'({1'b0, ~SPOL, ~SPOL, 1'b0, 8'h00}));
        chk("async_reset_addr", 32'(mif.mem_addr), 32'(BASE));
        expq.delete();
        expq.push_back('0);
        mh = 0;
        mv = 0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        #3 reset = 1'b1;
        repeat (50) cyc(1'b1, 1'b1);

        repeat (4) cyc(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
